// File: rtl/aes_result_collector_pkg.sv
// Shared AES result-collector types: the 264-bit output record, the FIFO entry and the FSM states.
package AESDefinitions;

  typedef logic [127:0] state_t;

  localparam int RESULT_BYTES = 33;

  typedef struct packed {
    state_t     encrypt;
    state_t     plain;
    logic [3:0] encryptValid;
    logic [3:0] plainValid;
  } outputResult_t;

  // FIFO entry: the visible record plus the end-of-message flag (265 bits).
  typedef struct packed {
    outputResult_t result;
    logic          eom;
  } fifoRecord_t;

  localparam int RECORD_WIDTH = $bits(fifoRecord_t);

  typedef enum logic [1:0] {
    ACTIVE,
    FLUSH,
    DRAIN,
    DONE
  } collectorState_t;

  function automatic outputResult_t makeResult(input logic encValid, input state_t encData,
                                               input logic plnValid, input state_t plnData);
    outputResult_t r;
    r.encrypt      = encValid ? encData : '0;
    r.plain        = plnValid ? plnData : '0;
    r.encryptValid = {4{encValid}};
    r.plainValid   = {4{plnValid}};
    return r;
  endfunction

  function automatic logic [15:0] satInc(input logic [15:0] value);
    return (value == 16'hFFFF) ? value : value + 16'd1;
  endfunction

endpackage

// File: rtl/aes_result_collector_result_fifo.sv
// First-word-fall-through result FIFO; a push is accepted when not full or when popping in the same cycle.
module result_fifo #(
  parameter int WIDTH = 265,
  parameter int DEPTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] pushData,
  input  logic             pop,
  output logic [WIDTH-1:0] headData,
  output logic             headValid,
  output logic             full
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wrPtr;
  logic [PTR_W-1:0] rdPtr;
  logic [CNT_W-1:0] count;
  logic             pushOk;
  logic             popOk;

  assign headValid = (count != '0);
  assign full      = (count == CNT_W'(DEPTH));
  assign popOk     = pop & headValid;
  assign pushOk    = push & (~full | popOk);
  assign headData  = mem[rdPtr];

  // NOTE: storage is deliberately not reset; the count alone decides what is visible.
  always_ff @(posedge clock) begin
    if (pushOk) mem[wrPtr] <= pushData;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (pushOk) wrPtr <= wrPtr + 1'b1;
      if (popOk)  rdPtr <= rdPtr + 1'b1;
      case ({pushOk, popOk})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/aes_result_collector.sv
// Collects encoder/decoder result blocks into a FWFT FIFO and appends an end-of-message marker on flush.
// Optional statistics counters are enabled by defining RESULT_STATS_EN.
module aes_result_collector
  import AESDefinitions::*;
#(
  parameter int DEPTH = 8
) (
  input  logic          clock,
  input  logic          reset,
  input  state_t        encryptIn,
  input  logic          encryptValid,
  input  state_t        plainIn,
  input  logic          plainValid,
  input  logic          flush,
  output outputResult_t outData,
  output logic          outEom,
  output logic          outValid,
  input  logic          outReady,
  output logic          done,
  output logic          overflow,
  output logic [15:0]   capCount,
  output logic [15:0]   dropCount
);

  collectorState_t state;
  collectorState_t nextState;
  fifoRecord_t     pushRecord;
  fifoRecord_t     headRecord;
  logic            fifoPush;
  logic            fifoPop;
  logic            fifoFull;
  logic            headValid;
  logic            canPush;
  logic            captureOk;
  logic            captureDrop;
  logic            markerPush;

  result_fifo #(
    .WIDTH (RECORD_WIDTH),
    .DEPTH (DEPTH)
  ) fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (fifoPush),
    .pushData  (pushRecord),
    .pop       (fifoPop),
    .headData  (headRecord),
    .headValid (headValid),
    .full      (fifoFull)
  );

  assign fifoPop  = headValid & outReady;
  assign canPush  = ~fifoFull | fifoPop;
  assign fifoPush = captureOk | markerPush;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    nextState   = state;
    captureOk   = 1'b0;
    captureDrop = 1'b0;
    markerPush  = 1'b0;
    pushRecord  = '0;
    case (state)
      ACTIVE: begin
        if (encryptValid | plainValid) begin
          if (canPush) begin
            captureOk         = 1'b1;
            pushRecord.result = makeResult(encryptValid, encryptIn, plainValid, plainIn);
          end else begin
            captureDrop = 1'b1;
          end
        end
        if (flush) nextState = FLUSH;
      end
      FLUSH: begin
        if (canPush) begin
          markerPush     = 1'b1;
          pushRecord.eom = 1'b1;
          nextState      = DRAIN;
        end
      end
      DRAIN: begin
        if (fifoPop && headRecord.eom) nextState = DONE;
      end
      DONE:    nextState = DONE;
      default: nextState = ACTIVE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= ACTIVE;
    else       state <= nextState;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset)            overflow <= 1'b0;
    else if (captureDrop) overflow <= 1'b1;
  end

  // Data is gated with valid so stale storage never leaks onto the output.
  assign outValid = headValid;
  assign outEom   = headValid & headRecord.eom;
  assign outData  = headValid ? headRecord.result : '0;
  assign done     = (state == DONE);

`ifdef RESULT_STATS_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      capCount  <= '0;
      dropCount <= '0;
    end else begin
      if (captureOk)   capCount  <= satInc(capCount);
      if (captureDrop) dropCount <= satInc(dropCount);
    end
  end
`else
  assign capCount  = '0;
  assign dropCount = '0;
`endif

endmodule

// File: tb/tb_aes_result_collector.sv
// Directed self-checking bench for aes_result_collector (DEPTH=8).
module tb_aes_result_collector;
  import AESDefinitions::*;

  localparam int DEPTH = 8;
`ifdef RESULT_STATS_EN
  localparam bit STATS_EN = 1'b1;
`else
  localparam bit STATS_EN = 1'b0;
`endif

  localparam logic [127:0] KEY_BLOCK = 128'h3925841D02DC09FBDC118597196A0B32;
  localparam logic [127:0] JUNK      = 128'hDEADBEEF_CAFEF00D_01234567_89ABCDEF;

  logic          clock = 1'b0;
  logic          reset;
  state_t        encryptIn;
  logic          encryptValid;
  state_t        plainIn;
  logic          plainValid;
  logic          flush;
  outputResult_t outData;
  logic          outEom;
  logic          outValid;
  logic          outReady;
  logic          done;
  logic          overflow;
  logic [15:0]   capCount;
  logic [15:0]   dropCount;

  int testsRun    = 0;
  int testsFailed = 0;

  aes_result_collector #(.DEPTH(DEPTH)) dut (
    .clock        (clock),
    .reset        (reset),
    .encryptIn    (encryptIn),
    .encryptValid (encryptValid),
    .plainIn      (plainIn),
    .plainValid   (plainValid),
    .flush        (flush),
    .outData      (outData),
    .outEom       (outEom),
    .outValid     (outValid),
    .outReady     (outReady),
    .done         (done),
    .overflow     (overflow),
    .capCount     (capCount),
    .dropCount    (dropCount)
  );

  always #5 clock = ~clock;

  task automatic checkValue(input string tag, input logic [263:0] actual, input logic [263:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("FAIL %s: got %h expected %h", tag, actual, expected);
    end
  endtask

  function automatic logic [15:0] expStat(input int n);
    return STATS_EN ? 16'(n) : 16'h0000;
  endfunction

  // Both halves valid; distinct tags per index make ordering errors visible.
  function automatic outputResult_t dataRec(input int i);
    outputResult_t r;
    r.encrypt      = {8'hE0, 120'(i)};
    r.plain        = {8'hA0, 120'(i)};
    r.encryptValid = 4'hF;
    r.plainValid   = 4'hF;
    return r;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clearValids();
    encryptValid = 1'b0;
    plainValid   = 1'b0;
    flush        = 1'b0;
  endtask

  task automatic doReset();
    reset    = 1'b1;
    outReady = 1'b0;
    clearValids();
    tick();
    reset = 1'b0;
  endtask

  task automatic capture(input logic ev, input logic [127:0] e, input logic pv, input logic [127:0] p);
    encryptValid = ev;
    encryptIn    = e;
    plainValid   = pv;
    plainIn      = p;
    tick();
    clearValids();
  endtask

  task automatic captureRec(input int i);
    outputResult_t r;
    r = dataRec(i);
    capture(1'b1, r.encrypt, 1'b1, r.plain);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    outputResult_t r;

    // Reset state, observed asynchronously before any clock edge.
    reset = 1'b1; outReady = 1'b0; encryptIn = JUNK; plainIn = JUNK;
    clearValids();
    #3;
    checkValue("rst_outValid", outValid, 0);
    checkValue("rst_outEom", outEom, 0);
    checkValue("rst_done", done, 0);
    checkValue("rst_overflow", overflow, 0);
    checkValue("rst_outData", outData, 0);
    checkValue("rst_capCount", capCount, 0);
    checkValue("rst_dropCount", dropCount, 0);
    tick();
    reset = 1'b0;

    // Single encrypt-only capture; the invalid plain half must be zeroed.
    outReady = 1'b1;
    capture(1'b1, KEY_BLOCK, 1'b0, JUNK);
    checkValue("single_outValid", outValid, 1);
    checkValue("single_encrypt", outData.encrypt, KEY_BLOCK);
    checkValue("single_encValid", outData.encryptValid, 4'hF);
    checkValue("single_plainValid", outData.plainValid, 4'h0);
    checkValue("single_plain", outData.plain, 0);
    checkValue("single_eom", outEom, 0);
    checkValue("single_capCount", capCount, expStat(1));
    tick();
    checkValue("single_popped", outValid, 0);
    checkValue("single_data_idle", outData, 0);

    // Backpressure: nine captures into eight entries, head held stable.
    doReset();
    for (int i = 1; i <= 9; i++) begin
      captureRec(i);
      checkValue("bp_head", outData, dataRec(1));
      if (i == DEPTH) checkValue("bp_no_overflow_yet", overflow, 0);
    end
    checkValue("bp_overflow", overflow, 1);
    checkValue("bp_dropCount", dropCount, expStat(1));
    checkValue("bp_capCount", capCount, expStat(8));

    // Full with simultaneous push and pop: no drop, order preserved.
    outReady = 1'b1;
    captureRec(10);
    checkValue("pp_head", outData, dataRec(2));
    checkValue("pp_dropCount", dropCount, expStat(1));
    checkValue("pp_capCount", capCount, expStat(9));
    for (int j = 0; j < DEPTH; j++) begin
      checkValue("pp_valid", outValid, 1);
      checkValue("pp_order", outData, dataRec((j < 7) ? j + 2 : 10));
      tick();
    end
    checkValue("pp_empty", outValid, 0);

    // Flush with three records; the third arrives in the flush cycle.
    doReset();
    captureRec(1);
    capture(1'b0, JUNK, 1'b1, 128'h0000_1111_2222_3333_4444_5555_6666_7777);
    r = dataRec(3);
    flush = 1'b1;
    capture(1'b1, r.encrypt, 1'b1, r.plain);
    encryptValid = 1'b1; encryptIn = JUNK;
    tick();
    tick();
    clearValids();
    checkValue("fl_done_early", done, 0);
    checkValue("fl_no_overflow", overflow, 0);
    outReady = 1'b1;
    checkValue("fl_rec1", outData, dataRec(1));
    tick();
    checkValue("fl_rec2", outData, {128'h0, 128'h0000_1111_2222_3333_4444_5555_6666_7777, 4'h0, 4'hF});
    tick();
    checkValue("fl_rec3", outData, dataRec(3));
    checkValue("fl_rec3_eom", outEom, 0);
    tick();
    checkValue("fl_marker_valid", outValid, 1);
    checkValue("fl_marker_eom", outEom, 1);
    checkValue("fl_marker_data", outData, 0);
    checkValue("fl_marker_done", done, 0);
    tick();
    checkValue("fl_done", done, 1);
    checkValue("fl_empty", outValid, 0);
    checkValue("fl_eom_idle", outEom, 0);
    captureRec(50);
    checkValue("fl_ignored", outValid, 0);
    checkValue("fl_capCount", capCount, expStat(3));
    checkValue("fl_dropCount", dropCount, expStat(0));
    checkValue("fl_done_sticky", done, 1);

    // Flush while full and stalled: marker waits, then lands behind eight records.
    doReset();
    for (int i = 1; i <= DEPTH; i++) captureRec(i);
    flush = 1'b1;
    tick();
    clearValids();
    encryptValid = 1'b1; encryptIn = JUNK;
    tick(); tick(); tick();
    clearValids();
    checkValue("ff_head", outData, dataRec(1));
    checkValue("ff_eom", outEom, 0);
    checkValue("ff_done", done, 0);
    checkValue("ff_overflow", overflow, 0);
    checkValue("ff_dropCount", dropCount, expStat(0));
    outReady = 1'b1;
    for (int j = 1; j <= DEPTH; j++) begin
      checkValue("ff_order", outData, dataRec(j));
      checkValue("ff_data_eom", outEom, 0);
      tick();
    end
    checkValue("ff_marker_eom", outEom, 1);
    checkValue("ff_marker_data", outData, 0);
    tick();
    checkValue("ff_done", done, 1);

    // Reset asserted mid-DRAIN away from a clock edge.
    doReset();
    for (int i = 1; i <= 9; i++) captureRec(i);
    flush = 1'b1;
    tick();
    clearValids();
    outReady = 1'b1;
    tick();
    outReady = 1'b0;
    checkValue("rd_pre_overflow", overflow, 1);
    checkValue("rd_pre_valid", outValid, 1);
    #3;
    reset = 1'b1;
    #1;
    checkValue("rd_outValid", outValid, 0);
    checkValue("rd_done", done, 0);
    checkValue("rd_overflow", overflow, 0);
    checkValue("rd_outData", outData, 0);
    checkValue("rd_outEom", outEom, 0);
    tick();
    reset = 1'b0;
    captureRec(77);
    checkValue("rd_first_valid", outValid, 1);
    checkValue("rd_first_rec", outData, dataRec(77));
    checkValue("rd_capCount", capCount, expStat(1));

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/aes_result_collector.md
AES_RESULT_COLLECTOR -- requirements
Module: aes_result_collector

Interface
REQ-001 Parameter: DEPTH, 8, result FIFO entries; power of two, minimum 2.
REQ-002 Port: clock  input  1  single clock; all state updates on rising edge.
REQ-003 Port: reset  input  1  asynchronous, active-high reset.
REQ-004 Port: encryptIn  input  128 (state_t)  encoder output block.
REQ-005 Port: encryptValid  input  1  encryptIn valid this cycle.
REQ-006 Port: plainIn  input  128 (state_t)  decoder output block.
REQ-007 Port: plainValid  input  1  plainIn valid this cycle.
REQ-008 Port: flush  input  1  single-cycle end-of-message request from the stimulus side.
REQ-009 Port: outData  output  264 (outputResult_t)  FIFO head record toward the HVL output pipe.
REQ-010 Port: outEom  output  1  head record is the end-of-message marker.
REQ-011 Port: outValid  output  1  head record present.
REQ-012 Port: outReady  input  1  consumer accepts head.
REQ-013 Port: done  output  1  marker delivered; sticky until reset.
REQ-014 Port: overflow  output  1  sticky; a capture was dropped.
REQ-015 Port: capCount, dropCount  output  16 each  statistics.

Function
REQ-016 A capture SHALL occur on any rising edge where (encryptValid | plainValid) is high, state is ACTIVE, and the FIFO is not full; one record per cycle.
REQ-017 The record SHALL hold encrypt=encryptIn, plain=plainIn, encryptValid={4{encryptValid}}, plainValid={4{plainValid}}, eom=0; an invalid half SHALL be stored as zero.
REQ-018 outValid SHALL rise in the cycle after the capturing edge; FIFO is first-word-fall-through.
REQ-019 Transfer SHALL occur on an edge with outValid & outReady; outData/outEom SHALL be held stable while outValid & !outReady.
REQ-020 When full, push and pop in the same cycle SHALL both succeed; count is unchanged.
REQ-021 Capture while full with no pop SHALL drop the record and set overflow.
REQ-022 States: ACTIVE, FLUSH, DRAIN, DONE.
REQ-023 ACTIVE->FLUSH on flush; a capture in the flush cycle SHALL still be accepted.
REQ-024 FLUSH: push the marker record (all data/valid fields zero, eom=1) on the first edge with space (not full, or popping); then ->DRAIN.
REQ-025 DRAIN->DONE on the edge the marker transfers; done=1 from the next cycle.
REQ-026 In FLUSH, DRAIN and DONE, captures and flush SHALL be ignored and SHALL NOT count as drops.
REQ-027 outEom SHALL equal the head record's eom bit and be 0 when outValid=0.

Reset
REQ-028 Asserting reset at any time SHALL immediately empty the FIFO, enter ACTIVE, and force outValid=0, outEom=0, done=0, overflow=0, capCount=0, dropCount=0, and outData=0.
REQ-029 Records in flight at reset SHALL be discarded without being signalled.

Configuration
REQ-030 With RESULT_STATS_EN defined, capCount SHALL increment per accepted capture and dropCount per dropped capture, both saturating at 16'hFFFF.
REQ-031 Without RESULT_STATS_EN, capCount and dropCount SHALL be constant 0 and no counter logic SHALL be synthesized; overflow is unaffected.

Structure
REQ-032 outputResult_t (encrypt, plain, encryptValid[3:0], plainValid[3:0]) and RESULT_BYTES=33 SHALL live in AESDefinitions.
REQ-033 FIFO storage, pointers and count SHALL be a sub-module result_fifo, parameterized by width (265) and DEPTH.

Verification
REQ-034 Single capture: encryptValid=1, encryptIn=128'h3925841D02DC09FBDC118597196A0B32, outReady=1 -> next cycle outValid=1, outData.encrypt matches, encryptValid=4'hF, plainValid=0, plain=0; capCount=1.
REQ-035 Backpressure: outReady=0, capture 9 records with DEPTH=8 -> first 8 retained in order, 9th dropped, overflow=1, dropCount=1; head stable throughout.
REQ-036 Full with simultaneous push and pop: FIFO full, outReady=1, capture -> no drop; order preserved; count stays 8.
REQ-037 Flush with 3 records queued -> three data records, then a marker with outEom=1 and zero data; done=1 one cycle after the marker transfers; later captures ignored.
REQ-038 Flush with FIFO full and outReady=0 -> stays in FLUSH; after outReady=1, the marker enters behind the 8 records.
REQ-039 Reset asserted mid-DRAIN, off a clock edge -> outValid, done and overflow are 0 immediately; a post-reset capture is the first record out.
